// File: rtl/seq_div16x16.sv
// seq_div16x16: multi-cycle radix-2 restoring divider, one quotient bit per clock.
// Produces the quotient and the remainder, with signed or unsigned operands.
// The remainder takes the dividend's sign (truncating division).
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   start            request, sampled only in IDLE
//   A, B             dividend, divisor
//   alu_signed       1 = two's-complement operands, 0 = unsigned
//   busy             high through the RUN and FIX cycles
//   done             one-cycle pulse when the results are valid
//   QUOT, REM        quotient and remainder, held until the next completion
//   div_by_zero      B was 0 for the completed operation
//   neg_flag         alu_signed & QUOT[MSB] for the completed operation
//   zero_flag        QUOT == 0 for the completed operation
module seq_div16x16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             alu_signed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] QUOT,
    output logic [WIDTH-1:0] REM,
    output logic             div_by_zero,
    output logic             neg_flag,
    output logic             zero_flag
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   dvd;        // dividend magnitude, becomes the quotient
    logic [WIDTH-1:0]   dvsr;       // divisor magnitude
    logic [WIDTH:0]     rem;        // partial remainder
    logic [CNT_W-1:0]   cnt;
    logic               sa;
    logic               sb;
    logic               sgn;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH+1:0]   shifted;
    logic [WIDTH+1:0]   trial;
    logic               q_bit;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (B == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    next_state = FIX;
                end
            end
            FIX:     next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand magnitudes, one restoring step, and sign fix-up
    always_comb begin
        abs_a    = (alu_signed && A[WIDTH-1]) ? WIDTH'(-A) : A;
        abs_b    = (alu_signed && B[WIDTH-1]) ? WIDTH'(-B) : B;
        shifted  = {rem, dvd[WIDTH-1]};
        trial    = shifted - {2'b00, dvsr};
        q_bit    = ~trial[WIDTH+1];
        quot_fix = (sa ^ sb) ? WIDTH'(-dvd) : dvd;
        rem_fix  = sa ? WIDTH'(-rem[WIDTH-1:0]) : rem[WIDTH-1:0];
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd         <= '0;
            dvsr        <= '0;
            rem         <= '0;
            cnt         <= '0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            sgn         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            QUOT        <= '0;
            REM         <= '0;
            div_by_zero <= 1'b0;
            neg_flag    <= 1'b0;
            zero_flag   <= 1'b1;
        end else begin
            busy <= (next_state == RUN) || (next_state == FIX);
            done <= (next_state == DONE);
            case (state)
                IDLE: begin
                    if (start && (B == '0)) begin
                        QUOT        <= '1;
                        REM         <= A;
                        div_by_zero <= 1'b1;
                        neg_flag    <= alu_signed;
                        zero_flag   <= 1'b0;
                    end else if (start) begin
                        sa   <= alu_signed & A[WIDTH-1];
                        sb   <= alu_signed & B[WIDTH-1];
                        sgn  <= alu_signed;
                        dvd  <= abs_a;
                        dvsr <= abs_b;
                        rem  <= '0;
                        cnt  <= CNT_W'(WIDTH - 1);
                    end
                end
                RUN: begin
                    rem <= q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
                    dvd <= {dvd[WIDTH-2:0], q_bit};
                    cnt <= cnt - CNT_W'(1);
                end
                FIX: begin
                    QUOT        <= quot_fix;
                    REM         <= rem_fix;
                    div_by_zero <= 1'b0;
                    neg_flag    <= sgn & quot_fix[WIDTH-1];
                    zero_flag   <= (quot_fix == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div16x16.sv
// Directed bench for seq_div16x16: results, flags, latency, handshake and reset abort.
module tb_seq_div16x16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        alu_signed;
    logic        busy;
    logic        done;
    logic [15:0] QUOT;
    logic [15:0] REM;
    logic        div_by_zero;
    logic        neg_flag;
    logic        zero_flag;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    int bc;

    seq_div16x16 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (A),
        .B           (B),
        .alu_signed  (alu_signed),
        .busy        (busy),
        .done        (done),
        .QUOT        (QUOT),
        .REM         (REM),
        .div_by_zero (div_by_zero),
        .neg_flag    (neg_flag),
        .zero_flag   (zero_flag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one cycle; returns in cycle T+1.
    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic s);
        A = a;
        B = b;
        alu_signed = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        A = 16'hA5A5;
        B = 16'h0000;
        alu_signed = ~s;
    endtask

    // Wait (bounded) for done; lat is the cycle offset from the start cycle.
    task automatic wait_done(input int lat0, output int l, output int nb);
        l  = lat0;
        nb = 0;
        while (!done && l < 40) begin
            nb += int'(busy);
            tick();
            l++;
        end
    endtask

    task automatic check_res(input string tag, input logic [15:0] eq, input logic [15:0] er,
                             input logic edz, input logic eneg, input logic ezero);
        check({tag, " quot"}, 32'(QUOT), 32'(eq));
        check({tag, " rem"},  32'(REM),  32'(er));
        check({tag, " dz"},   32'(div_by_zero), 32'(edz));
        check({tag, " neg"},  32'(neg_flag),    32'(eneg));
        check({tag, " zero"}, 32'(zero_flag),   32'(ezero));
    endtask

    // Full operation: latency, busy length, results, done pulse width.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [15:0] eq, input logic [15:0] er,
                          input logic edz, input logic eneg, input logic ezero, input int elat);
        int l;
        int nb;
        launch(a, b, s);
        wait_done(1, l, nb);
        check({tag, " latency"}, 32'(l), 32'(elat));
        check({tag, " busy cycles"}, 32'(nb), (elat == 1) ? 32'd0 : 32'd17);
        check({tag, " busy at done"}, 32'(busy), 32'd0);
        check_res(tag, eq, er, edz, eneg, ezero);
        tick();
        check({tag, " done pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        A = 16'h0;
        B = 16'h0;
        alu_signed = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check_res("reset", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);

        run_op("udiv 100/7", 16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0, 1'b0, 1'b0, 18);
        run_op("sdiv -7/2", 16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 1'b1, 1'b0, 18);
        run_op("sdiv ovf", 16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0, 18);
        run_op("udiv 8000/ffff", 16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b1, 18);
        run_op("udiv by 0", 16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1'b0, 1);
        run_op("sdiv by 0", 16'h1234, 16'h0000, 1'b1, 16'hFFFF, 16'h1234, 1'b1, 1'b1, 1'b0, 1);
        run_op("sdiv 7/-2", 16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 1'b1, 1'b0, 18);
        run_op("udiv ffff/1", 16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 18);

        // Second start mid-operation is ignored
        launch(16'd50, 16'd5, 1'b0);
        tick(); tick(); tick(); tick();
        check("hs busy at T+5", 32'(busy), 32'd1);
        A = 16'd9;
        B = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(6, lat, bc);
        check("hs latency", 32'(lat), 32'd18);
        check_res("hs", 16'd10, 16'd0, 1'b0, 1'b0, 1'b0);
        tick();

        // Reset mid-run aborts with no done, then a fresh start completes
        launch(16'd50, 16'd5, 1'b0);
        tick(); tick(); tick(); tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check_res("abort", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        tick();
        check("abort no late done", 32'(done), 32'd0);
        run_op("after abort", 16'd50, 16'd5, 1'b0, 16'd10, 16'd0, 1'b0, 1'b0, 1'b0, 18);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_div16x16.md
# seq_div16x16

Multi-cycle 16-bit by 16-bit integer divider producing quotient and remainder, signed or unsigned per operation. It is the inverse of the single-cycle Booth multiplier datapath and shares its operand and flag conventions, so the ALU can route MUL and DIV/REM operations through one operand/flag interface. It uses a radix-2 restoring iteration, one quotient bit per clock, behind a start/busy/done handshake.

## Interface
- WIDTH, 16, operand and result width; only 16 is required to be supported.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- A  in  16  dividend.
- B  in  16  divisor.
- alu_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- busy  out  1  high from the cycle after an accepted start until `done`, exclusive.
- done  out  1  one-cycle pulse when results are valid.
- QUOT  out  16  quotient; held until the next accepted start.
- REM  out  16  remainder; held until the next accepted start.
- div_by_zero  out  1  B was 0 for the completed operation.
- neg_flag  out  1  alu_signed & QUOT[15], from the completed operation.
- zero_flag  out  1  QUOT == 0, from the completed operation.

## Operation
- States: IDLE, RUN, FIX, DONE.
- **IDLE**: `start` = 1 captures A, B and alu_signed.
  - If B == 0, go to DONE with QUOT = 16'hFFFF, REM = A, div_by_zero = 1.
  - Otherwise latch the dividend sign sA = alu_signed & A[15] and the divisor sign sB = alu_signed & B[15].
  - Load the magnitudes |A| and |B|. |0x8000| = 0x8000 as a 16-bit unsigned value.
  - Clear the 17-bit partial remainder, load the iteration counter with 15, and go to RUN.
- **RUN** (16 cycles): each cycle does the following.
  - Shift {rem, dvd} left one bit.
  - Compute trial = rem − |B| over 17 bits.
  - If trial ≥ 0, set rem = trial and shift in quotient bit 1; otherwise shift in 0.
  - Decrement the counter; after the cycle where the counter is 0, go to FIX.
- **FIX**: apply signs.
  - QUOT = (sA ^ sB) ? −q : q.
  - REM = sA ? −r : r. The remainder takes the dividend's sign (truncating division).
  - Go to DONE.
- **DONE**: `done` = 1 for exactly one cycle, then IDLE.
  - Outputs and flags update on entry to DONE and hold until the next accepted start.
- **Signed overflow**: 0x8000 / 0xFFFF gives QUOT = 0x8000, REM = 0, neg_flag = 1. This falls out of the datapath; no special case is needed.
- `start` in any state other than IDLE is ignored, with no queueing.
- `start` in the same cycle that DONE returns to IDLE is not accepted; it is only sampled once the block is in IDLE.
- Inputs A, B and alu_signed may change freely after the capture cycle.

## Timing
- **Normal latency**: start sampled in cycle T; RUN occupies T+1..T+16; FIX is T+17; `done` is high in T+18.
  - The earliest next start is accepted at T+19.
- **Divide-by-zero latency**: `done` is high in T+1, `busy` never asserts, and the next start is accepted at T+2.
- `busy` is high in T+1..T+17 for normal operations.
- **Reset values** (rst high at a clock edge):
  - State = IDLE.
  - busy, done, div_by_zero, neg_flag = 0.
  - QUOT, REM = 0.
  - zero_flag = 1, consistent with QUOT = 0.
- Reset during RUN or FIX aborts the operation with no `done` pulse; it takes priority over `start` in the same cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Unsigned divide**: alu_signed = 0, A = 100, B = 7, start at T.
  - done at T+18; QUOT = 14, REM = 2; all flags 0.
  - busy high for exactly 17 cycles.
- **Signed, negative dividend**: alu_signed = 1, A = 0xFFF9 (−7), B = 0x0002.
  - QUOT = 0xFFFD (−3), REM = 0xFFFF (−1), neg_flag = 1, zero_flag = 0.
- **Signed overflow**: alu_signed = 1, A = 0x8000, B = 0xFFFF.
  - QUOT = 0x8000, REM = 0, neg_flag = 1.
- **Same operands, unsigned**: alu_signed = 0, A = 0x8000, B = 0xFFFF.
  - QUOT = 0, REM = 0x8000, zero_flag = 1.
- **Divide by zero**: A = 0x1234, B = 0, either signedness.
  - done at T+1; QUOT = 0xFFFF, REM = 0x1234, div_by_zero = 1.
  - A following normal operation clears div_by_zero.
- **Handshake and reset**:
  - Start with A = 50, B = 5; pulse start again at T+5 with A = 9, B = 3; the second start is ignored and results are QUOT = 10, REM = 0.
  - Repeat with rst at T+8: no done pulse follows, outputs return to reset values, and a start at T+10 completes at T+28.
